hub75_scan_driver: RTL and testbench



---
 rtl/led_panel_pkg.sv | 38 +++
 rtl/hub75_scan_driver_bcm_plane_timer.sv | 32 +++
 rtl/hub75_scan_driver.sv | 190 +++++++++++++++++++
 tb/tb_hub75_scan_driver.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_panel_pkg.sv
// Shared definitions for the LED panel path: panel geometry, pixel address
// layout, scan state encoding, colour constants and a bit-plane helper.
package led_panel_pkg;

   localparam int PANEL_COLS = 64;
   localparam int PANEL_ROWS = 32;
   localparam int SCAN_ROWS  = 16;

   // pixel_addr = {row[ROW_W-1:0], col[COL_W-1:0]}
   localparam int ROW_W  = 5;
   localparam int COL_W  = 6;
   localparam int ADDR_W = ROW_W + COL_W;
   localparam int PIX_W  = 24;

   typedef enum logic [1:0] {
      SCAN_SHIFT   = 2'd0,
      SCAN_BLANK   = 2'd1,
      SCAN_LATCH   = 2'd2,
      SCAN_DISPLAY = 2'd3
   } scan_state_e;

   localparam logic [PIX_W-1:0] RED   = 24'hFF0000;
   localparam logic [PIX_W-1:0] BLUE  = 24'h0000FF;
   localparam logic [PIX_W-1:0] BLACK = 24'h000000;

   // Pick one bit of each colour channel, returned as {R, G, B}.
   function automatic logic [2:0] plane_bits(input logic [PIX_W-1:0] pix,
                                             input logic [2:0]       idx);
      logic [7:0] red_ch;
      logic [7:0] grn_ch;
      logic [7:0] blu_ch;
      red_ch = pix[23:16];
      grn_ch = pix[15:8];
      blu_ch = pix[7:0];
      plane_bits = {red_ch[idx], grn_ch[idx], blu_ch[idx]};
   endfunction

endpackage

// File: rtl/hub75_scan_driver_bcm_plane_timer.sv
// Down-counter that times the OE-low window of one bit plane. Loading with
// plane p starts a window of BASE_ON<<p cycles; done marks its last cycle.
module bcm_plane_timer #(
   parameter int BASE_ON = 8,
   parameter int PLANE_W = 2,
   parameter int CNT_W   = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic [PLANE_W-1:0] plane,
   output logic               done
);

   logic [CNT_W-1:0] cnt_r;

   // Load the plane duration, then count down to zero and park there.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= '0;
      end else if (load) begin
         cnt_r <= CNT_W'(BASE_ON) << plane;
      end else if (cnt_r != '0) begin
         cnt_r <= cnt_r - CNT_W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign done = (cnt_r == CNT_W'(1));

endmodule

// File: rtl/hub75_scan_driver.sv
// HUB75 1/16-scan driver for a 64x32 panel. Each column fetches the upper and
// lower pixel from the generator, shifts one bit plane into the panel, then
// blanks, latches and shows the plane for a binary-weighted OE window.
module hub75_scan_driver #(
   parameter int BITS      = 3,
   parameter int BASE_ON   = 8,
   parameter int BLANK_CYC = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic [10:0] pixel_addr,
   input  logic [23:0] pixel_data,
   output logic        r1,
   output logic        g1,
   output logic        b1,
   output logic        r2,
   output logic        g2,
   output logic        b2,
   output logic [3:0]  row_addr,
   output logic        panel_clk,
   output logic        panel_lat,
   output logic        panel_oe_n,
   output logic        frame_start
);

   import led_panel_pkg::*;

   localparam int PLANE_W = (BITS > 1) ? $clog2(BITS) : 1;
   localparam int ON_MAX  = BASE_ON << (BITS - 1);
   localparam int CNT_W   = $clog2(ON_MAX + 1);
   localparam int BLK_W   = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;

   localparam logic [PLANE_W-1:0] LAST_PLANE = PLANE_W'(BITS - 1);
   localparam logic [BLK_W-1:0]   LAST_BLK   = BLK_W'(BLANK_CYC - 1);
   localparam logic [COL_W-1:0]   LAST_COL   = COL_W'(PANEL_COLS - 1);
   localparam logic [2:0]         BIT_BASE   = 3'(8 - BITS);

   localparam logic [1:0] ST_SHIFT   = SCAN_SHIFT;
   localparam logic [1:0] ST_BLANK   = SCAN_BLANK;
   localparam logic [1:0] ST_LATCH   = SCAN_LATCH;
   localparam logic [1:0] ST_DISPLAY = SCAN_DISPLAY;

   logic [1:0]         state_r;
   logic [1:0]         phase_r;
   logic [COL_W-1:0]   col_r;
   logic [3:0]         row_r;
   logic [PLANE_W-1:0] plane_r;
   logic [BLK_W-1:0]   blank_cnt_r;
   logic               started_r;
   logic [23:0]        upper_r;

   logic [PLANE_W-1:0] next_plane_s;
   logic [3:0]         next_row_s;
   logic [2:0]         bit_idx_s;
   logic               timer_load_s;
   logic               timer_done_s;

   // Plane/row advance after a display window and the channel bit to shift.
   always_comb begin
      next_plane_s = '0;
      next_row_s   = row_r;
      bit_idx_s    = BIT_BASE + 3'(plane_r);
      timer_load_s = (state_r == ST_LATCH);
      if (plane_r == LAST_PLANE) begin
         next_plane_s = '0;
         next_row_s   = row_r + 4'd1;
      end else begin
         next_plane_s = plane_r + PLANE_W'(1);
         next_row_s   = row_r;
      end
   end

   bcm_plane_timer #(
      .BASE_ON (BASE_ON),
      .PLANE_W (PLANE_W),
      .CNT_W   (CNT_W)
   ) u_timer (
      .clk   (clk),
      .rst   (rst),
      .load  (timer_load_s),
      .plane (plane_r),
      .done  (timer_done_s)
   );

   // Scan sequencer: every output is registered and describes the cycle it
   // is visible in (pixel_addr in ph0/ph1, data pins from ph2, clock in ph3).
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_SHIFT;
         phase_r     <= 2'd0;
         col_r       <= '0;
         row_r       <= 4'd0;
         plane_r     <= '0;
         blank_cnt_r <= '0;
         started_r   <= 1'b0;
         upper_r     <= 24'd0;
         pixel_addr  <= 11'd0;
         r1          <= 1'b0;
         g1          <= 1'b0;
         b1          <= 1'b0;
         r2          <= 1'b0;
         g2          <= 1'b0;
         b2          <= 1'b0;
         row_addr    <= 4'd0;
         panel_clk   <= 1'b0;
         panel_lat   <= 1'b0;
         panel_oe_n  <= 1'b1;
         frame_start <= 1'b0;
      end else begin
         frame_start <= 1'b0;
         if (!started_r) begin
            // First cycle out of reset announces the frame; pixel_addr
            // already points at row 0, col 0 upper.
            started_r   <= 1'b1;
            frame_start <= 1'b1;
         end else begin
            case (state_r)
               ST_SHIFT: begin
                  case (phase_r)
                     2'd0: begin
                        upper_r    <= pixel_data;
                        pixel_addr <= {1'b1, row_r, col_r};
                        phase_r    <= 2'd1;
                     end
                     2'd1: begin
                        {r1, g1, b1} <= plane_bits(upper_r, bit_idx_s);
                        {r2, g2, b2} <= plane_bits(pixel_data, bit_idx_s);
                        phase_r      <= 2'd2;
                     end
                     2'd2: begin
                        panel_clk <= 1'b1;
                        phase_r   <= 2'd3;
                     end
                     2'd3: begin
                        panel_clk <= 1'b0;
                        phase_r   <= 2'd0;
                        if (col_r == LAST_COL) begin
                           col_r       <= '0;
                           state_r     <= ST_BLANK;
                           row_addr    <= row_r;
                           blank_cnt_r <= '0;
                        end else begin
                           col_r      <= col_r + COL_W'(1);
                           pixel_addr <= {1'b0, row_r, col_r + COL_W'(1)};
                        end
                     end
                     default: begin
                        phase_r <= 2'd0;
                     end
                  endcase
               end
               ST_BLANK: begin
                  if (blank_cnt_r == LAST_BLK) begin
                     state_r   <= ST_LATCH;
                     panel_lat <= 1'b1;
                  end else begin
                     blank_cnt_r <= blank_cnt_r + BLK_W'(1);
                  end
               end
               ST_LATCH: begin
                  panel_lat  <= 1'b0;
                  panel_oe_n <= 1'b0;
                  state_r    <= ST_DISPLAY;
               end
               ST_DISPLAY: begin
                  if (timer_done_s) begin
                     panel_oe_n  <= 1'b1;
                     plane_r     <= next_plane_s;
                     row_r       <= next_row_s;
                     state_r     <= ST_SHIFT;
                     phase_r     <= 2'd0;
                     pixel_addr  <= {1'b0, next_row_s, 6'd0};
                     frame_start <= (next_row_s == 4'd0) && (next_plane_s == '0);
                  end else begin
                     panel_oe_n <= 1'b0;
                  end
               end
               default: begin
                  state_r    <= ST_SHIFT;
                  phase_r    <= 2'd0;
                  panel_clk  <= 1'b0;
                  panel_lat  <= 1'b0;
                  panel_oe_n <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_hub75_scan_driver.sv
// Self-checking bench for hub75_scan_driver. The reference model derives the
// expected pins from the cycle index alone (frame/row/plane arithmetic) and
// an image that the bench owns and drives back through pixel_data.
module tb_hub75_scan_driver;

   localparam int BITS      = 3;
   localparam int BASE_ON   = 8;
   localparam int BLANK_CYC = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [10:0] pixel_addr;
   logic [23:0] pixel_data;
   logic        r1, g1, b1, r2, g2, b2;
   logic [3:0]  row_addr;
   logic        panel_clk, panel_lat, panel_oe_n, frame_start;

   int checks   = 0;
   int failures = 0;

   int          mode;
   logic [23:0] img [0:2047];

   // Generator stand-in: mode 1 solid red, mode 2 split halves, else image.
   assign pixel_data = (mode == 1) ? 24'hFF0000 :
                       (mode == 2) ? (pixel_addr[10] ? 24'h0000FF : 24'h800000) :
                       img[pixel_addr];

   hub75_scan_driver #(
      .BITS      (BITS),
      .BASE_ON   (BASE_ON),
      .BLANK_CYC (BLANK_CYC)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .pixel_addr  (pixel_addr),
      .pixel_data  (pixel_data),
      .r1          (r1),
      .g1          (g1),
      .b1          (b1),
      .r2          (r2),
      .g2          (g2),
      .b2          (b2),
      .row_addr    (row_addr),
      .panel_clk   (panel_clk),
      .panel_lat   (panel_lat),
      .panel_oe_n  (panel_oe_n),
      .frame_start (frame_start)
   );

   always #5 clk = ~clk;

   // Hard stop in case something stalls the sequence.
   initial begin
      #2000000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0d", tag, got, exp, t);
      end
   endtask

   function automatic int plane_len(input int p);
      return 256 + BLANK_CYC + 1 + (BASE_ON << p);
   endfunction

   function automatic int row_cycles();
      int s;
      s = 0;
      for (int p = 0; p < BITS; p++) s += plane_len(p);
      return s;
   endfunction

   localparam int ROWC  = 256 * BITS + (BLANK_CYC + 1) * BITS + BASE_ON * ((1 << BITS) - 1);
   localparam int FRAME = 16 * ROWC;

   function automatic logic [23:0] model_pix(input logic [10:0] a);
      if (mode == 1) return 24'hFF0000;
      else if (mode == 2) return (a >= 11'd1024) ? 24'h0000FF : 24'h800000;
      else return img[a];
   endfunction

   function automatic logic [2:0] chan_bits(input logic [23:0] d, input int plane);
      int b;
      b = 8 - BITS + plane;
      return {d[16 + b], d[8 + b], d[b]};
   endfunction

   // model state
   int          t;
   int          m_st, m_row, m_plane, m_col, m_ph, m_off;
   logic [10:0] e_addr;
   logic [5:0]  e_rgb;
   logic [3:0]  e_row_addr;
   int          clk_edges, oe_cnt, pend_len;
   logic        prev_clk, prev_oe;

   task automatic model_reset();
      t = 0; e_addr = 11'd0; e_rgb = 6'd0; e_row_addr = 4'd0;
      clk_edges = 0; oe_cnt = 0; pend_len = 0; prev_clk = 1'b0; prev_oe = 1'b1;
   endtask

   // Compare every pin for cycle t, sampled mid-cycle.
   task automatic check_cycle();
      int pos, rem;
      logic [10:0] ua, la;
      mode = ((t / FRAME) == 0) ? 1 : ((t / FRAME) == 1) ? 2 : 0;
      pos = t % FRAME;
      m_row = pos / ROWC;
      rem = pos % ROWC;
      m_plane = 0;
      while (rem >= plane_len(m_plane)) begin
         rem -= plane_len(m_plane);
         m_plane++;
      end
      m_off = rem; m_col = 0; m_ph = 0;
      if (rem < 256) begin m_st = 0; m_col = rem / 4; m_ph = rem % 4; end
      else if (rem < 256 + BLANK_CYC) m_st = 1;
      else if (rem == 256 + BLANK_CYC) m_st = 2;
      else m_st = 3;
      ua = 11'(m_row * 64 + m_col);
      la = 11'(1024 + m_row * 64 + m_col);
      if (m_st == 0 && m_ph == 0) e_addr = ua;
      if (m_st == 0 && m_ph == 1) e_addr = la;
      if (m_st == 0 && m_ph == 2) e_rgb = {chan_bits(model_pix(ua), m_plane), chan_bits(model_pix(la), m_plane)};
      if (m_st == 1 && m_off == 256) e_row_addr = 4'(m_row);

      check_val("pixel_addr", 32'(pixel_addr), 32'(e_addr));
      check_val("rgb", 32'({r1, g1, b1, r2, g2, b2}), 32'(e_rgb));
      check_val("row_addr", 32'(row_addr), 32'(e_row_addr));
      check_val("panel_clk", 32'(panel_clk), 32'(m_st == 0 && m_ph == 3));
      check_val("panel_lat", 32'(panel_lat), 32'(m_st == 2));
      check_val("panel_oe_n", 32'(panel_oe_n), 32'(m_st != 3));
      check_val("frame_start", 32'(frame_start), 32'(pos == 0));
      check_val("lat_while_clk", 32'(panel_lat & panel_clk), 32'd0);
      if (m_st == 0 && m_row == 3 && m_col == 5 && m_ph == 0)
         check_val("addr_r3c5_ph0", 32'(pixel_addr), 32'd197);
      if (m_st == 0 && m_row == 3 && m_col == 5 && m_ph == 1)
         check_val("addr_r3c5_ph1", 32'(pixel_addr), 32'd1221);

      if (panel_clk && !prev_clk) clk_edges++;
      if (panel_lat) begin
         check_val("clk_edges_per_plane", 32'(clk_edges), 32'd64);
         clk_edges = 0;
      end
      if (!panel_oe_n) oe_cnt++;
      if (panel_oe_n && !prev_oe) begin
         check_val("oe_low_len", 32'(oe_cnt), 32'(pend_len));
         oe_cnt = 0;
      end
      if (m_st == 2) pend_len = BASE_ON << m_plane;
      prev_clk = panel_clk;
      prev_oe  = panel_oe_n;

      // New image content only while the panel is displaying, so a change
      // lands on whole columns sampled afterwards.
      if (mode == 0 && m_st == 3 && $urandom_range(0, 199) == 0)
         for (int i = 0; i < 2048; i++) img[i] = 24'($urandom);
   endtask

   initial begin
      logic found;
      for (int i = 0; i < 2048; i++) img[i] = 24'($urandom);
      mode = 1;
      rst  = 1'b1;
      t    = 0;
      repeat (3) @(negedge clk);
      check_val("rst_pixel_addr", 32'(pixel_addr), 32'd0);
      check_val("rst_rgb", 32'({r1, g1, b1, r2, g2, b2}), 32'd0);
      check_val("rst_row_addr", 32'(row_addr), 32'd0);
      check_val("rst_panel_clk", 32'(panel_clk), 32'd0);
      check_val("rst_panel_lat", 32'(panel_lat), 32'd0);
      check_val("rst_panel_oe_n", 32'(panel_oe_n), 32'd1);
      check_val("rst_frame_start", 32'(frame_start), 32'd0);
      check_val("row_cycles", 32'(row_cycles()), 32'd833);

      rst = 1'b0;
      @(negedge clk);
      model_reset();
      check_val("first_frame_start", 32'(frame_start), 32'd1);

      // Two full frames: solid red, then split halves.
      for (int i = 0; i < 2 * FRAME; i++) begin
         check_cycle();
         if (failures > 50) break;
         @(negedge clk);
         t++;
      end

      // Random image frame until DISPLAY of row 7, plane 1.
      found = 1'b0;
      for (int i = 0; i < FRAME; i++) begin
         check_cycle();
         if (failures > 50) break;
         if (m_st == 3 && m_row == 7 && m_plane == 1) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
         t++;
      end
      check_val("reached_r7_p1_display", 32'(found), 32'd1);

      rst = 1'b1;
      @(negedge clk);
      check_val("midrst_oe_n", 32'(panel_oe_n), 32'd1);
      check_val("midrst_lat", 32'(panel_lat), 32'd0);
      check_val("midrst_row_addr", 32'(row_addr), 32'd0);
      check_val("midrst_pixel_addr", 32'(pixel_addr), 32'd0);
      check_val("midrst_frame_start", 32'(frame_start), 32'd0);

      rst = 1'b0;
      @(negedge clk);
      model_reset();
      for (int i = 0; i < 3000; i++) begin
         check_cycle();
         if (failures > 50) break;
         @(negedge clk);
         t++;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
